// File: rtl/write_router.sv
// Scatters a latched packed vector into the element buffer, one element per cycle from startAddr (wrapping mod Depth).
// First write on the edge after accept; bufReady=0 stalls index/address/data and drops writeEn.
module write_router #(
  parameter int MaxWidth  = 9,
  parameter int Depth     = 32,
  parameter int DataWidth = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              routeEn,
  input  logic [$clog2(Depth)-1:0]          startAddr,
  input  logic [$clog2(MaxWidth+1)-1:0]     count,
  input  logic [MaxWidth*DataWidth-1:0]     dataIn,
  input  logic                              bufReady,
  output logic                              ready,
  output logic                              writeEn,
  output logic [$clog2(Depth)-1:0]          writeAddr,
  output logic [DataWidth-1:0]              dataOut,
  output logic                              finished
);

  localparam int AddrWidth  = $clog2(Depth);
  localparam int CountWidth = $clog2(MaxWidth + 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                         state, state_nxt;
  logic [MaxWidth*DataWidth-1:0]  vec;
  logic [AddrWidth-1:0]           addr;
  logic [CountWidth-1:0]          eff_cnt;
  logic [CountWidth-1:0]          idx;
  logic [CountWidth-1:0]          cnt_clamped;
  logic                           accept;
  logic                           fire;
  logic                           last;

  assign cnt_clamped = (count > CountWidth'(MaxWidth)) ? CountWidth'(MaxWidth) : count;
  assign accept      = (state == IDLE) && routeEn;
  assign fire        = (state == WRITE) && bufReady;
  assign last        = fire && ((idx + CountWidth'(1)) == eff_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (routeEn) state_nxt = (cnt_clamped == '0) ? DONE : WRITE;
      WRITE:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Running address wraps explicitly so non-power-of-two depths also work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec     <= '0;
      addr    <= '0;
      eff_cnt <= '0;
      idx     <= '0;
    end else if (accept) begin
      vec     <= dataIn;
      addr    <= startAddr;
      eff_cnt <= cnt_clamped;
      idx     <= '0;
    end else if (fire) begin
      idx  <= idx + CountWidth'(1);
      addr <= (addr == AddrWidth'(Depth - 1)) ? '0 : addr + AddrWidth'(1);
    end
  end

  always_comb begin
    ready     = (state == IDLE);
    writeEn   = fire;
    finished  = (state == DONE);
    writeAddr = (state == WRITE) ? addr : '0;
    dataOut   = '0;
    if (state == WRITE) begin
      for (int i = 0; i < MaxWidth; i++) begin
        if (idx == CountWidth'(i)) dataOut = vec[i*DataWidth +: DataWidth];
      end
    end
  end

endmodule

// File: tb/tb_write_router.sv
// Directed table-driven bench for write_router with hand-written reset-abort sequence.
module tb_write_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        routeEn;
  logic [4:0]  startAddr;
  logic [3:0]  count;
  logic [71:0] dataIn;
  logic        bufReady;
  logic        ready;
  logic        writeEn;
  logic [4:0]  writeAddr;
  logic [7:0]  dataOut;
  logic        finished;

  int checks   = 0;
  int failures = 0;

  write_router dut (
    .clk       (clk),
    .rst       (rst),
    .routeEn   (routeEn),
    .startAddr (startAddr),
    .count     (count),
    .dataIn    (dataIn),
    .bufReady  (bufReady),
    .ready     (ready),
    .writeEn   (writeEn),
    .writeAddr (writeAddr),
    .dataOut   (dataOut),
    .finished  (finished)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        re;
    logic [4:0]  sa;
    logic [3:0]  c;
    logic [71:0] d;
    logic        br;
    logic        er;
    logic        ewe;
    logic [4:0]  ea;
    logic [7:0]  ed;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [71:0] mk(input logic [7:0] b);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = b + 8'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step%0d actual=%0h expected=%0h", nm, n, act, exp);
    end
  endtask

  task automatic chk_out(input int n, input logic er, input logic ewe, input logic [4:0] ea,
                         input logic [7:0] ed, input logic ef);
    chk("ready",     n, 32'(ready),     32'(er));
    chk("writeEn",   n, 32'(writeEn),   32'(ewe));
    chk("writeAddr", n, 32'(writeAddr), 32'(ea));
    chk("dataOut",   n, 32'(dataOut),   32'(ed));
    chk("finished",  n, 32'(finished),  32'(ef));
  endtask

  task automatic apply(input vec_t v, input int n);
    @(negedge clk);
    routeEn   = v.re;
    startAddr = v.sa;
    count     = v.c;
    dataIn    = v.d;
    bufReady  = v.br;
    #1;
    chk_out(n, v.er, v.ewe, v.ea, v.ed, v.ef);
  endtask

  task automatic add(input logic re, input logic [4:0] sa, input logic [3:0] c, input logic [71:0] d,
                     input logic br, input logic er, input logic ewe, input logic [4:0] ea,
                     input logic [7:0] ed, input logic ef);
    vecs.push_back('{re, sa, c, d, br, er, ewe, ea, ed, ef});
  endtask

  task automatic acc(input logic [4:0] sa, input logic [3:0] c, input logic [71:0] d);
    add(1'b1, sa, c, d, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
  endtask

  task automatic idle();
    add(1'b0, 5'd0, 4'd0, 72'd0, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
  endtask

  task automatic wr(input logic br, input logic [4:0] ea, input logic [7:0] ed);
    add(1'b0, 5'd0, 4'd0, 72'd0, br, 1'b0, br, ea, ed, 1'b0);
  endtask

  task automatic done_v(input logic re);
    add(re, 5'd9, 4'd1, mk(8'hEE), 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
  endtask

  initial begin
    vec_t v;
    // Full 9-element transfer from address 4.
    acc(5'd4, 4'd9, mk(8'h11));
    for (int i = 0; i < 9; i++) wr(1'b1, 5'(4 + i), 8'(8'h11 + i));
    done_v(1'b0);
    idle();
    // Address wrap.
    acc(5'd30, 4'd4, mk(8'hA0));
    wr(1'b1, 5'd30, 8'hA0);
    wr(1'b1, 5'd31, 8'hA1);
    wr(1'b1, 5'd0,  8'hA2);
    wr(1'b1, 5'd1,  8'hA3);
    done_v(1'b0);
    idle();
    // Two-cycle stall on the second element.
    acc(5'd10, 4'd3, mk(8'h30));
    wr(1'b1, 5'd10, 8'h30);
    wr(1'b0, 5'd11, 8'h31);
    wr(1'b0, 5'd11, 8'h31);
    wr(1'b1, 5'd11, 8'h31);
    wr(1'b1, 5'd12, 8'h32);
    done_v(1'b0);
    idle();
    // Zero count.
    acc(5'd5, 4'd0, mk(8'h40));
    done_v(1'b0);
    idle();
    // Count above MaxWidth clamps to 9.
    acc(5'd20, 4'd12, mk(8'h50));
    for (int i = 0; i < 9; i++) wr(1'b1, 5'(20 + i), 8'(8'h50 + i));
    done_v(1'b0);
    idle();
    // routeEn mid-transfer with different inputs is ignored.
    acc(5'd2, 4'd3, mk(8'h60));
    wr(1'b1, 5'd2, 8'h60);
    add(1'b1, 5'd17, 4'd5, mk(8'h70), 1'b1, 1'b0, 1'b1, 5'd3, 8'h61, 1'b0);
    wr(1'b1, 5'd4, 8'h62);
    done_v(1'b0);
    idle();
    // routeEn held high: one IDLE cycle between transfers.
    acc(5'd0, 4'd1, mk(8'h80));
    add(1'b1, 5'd7, 4'd1, mk(8'h90), 1'b1, 1'b0, 1'b1, 5'd0, 8'h80, 1'b0);
    done_v(1'b1);
    acc(5'd6, 4'd1, mk(8'h90));
    wr(1'b1, 5'd6, 8'h90);
    done_v(1'b0);
    idle();

    rst = 1'b0; routeEn = 1'b0; startAddr = '0; count = '0; dataIn = '0; bufReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_out(-1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    rst = 1'b1;

    for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);

    // Reset during the 5th write of a 9-element transfer.
    v = '{1'b1, 5'd0, 4'd9, mk(8'h11), 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0};
    apply(v, 100);
    for (int i = 0; i < 5; i++) begin
      v = '{1'b0, 5'd0, 4'd0, 72'd0, 1'b1, 1'b0, 1'b1, 5'(i), 8'(8'h11 + i), 1'b0};
      apply(v, 101 + i);
    end
    rst = 1'b0;
    #1;
    chk_out(110, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    v = '{1'b0, 5'd0, 4'd0, 72'd0, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0};
    apply(v, 111);
    rst = 1'b1;
    apply(v, 112);
    v = '{1'b1, 5'd0, 4'd2, mk(8'hC0), 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0};
    apply(v, 113);
    v = '{1'b0, 5'd0, 4'd0, 72'd0, 1'b1, 1'b0, 1'b1, 5'd0, 8'hC0, 1'b0};
    apply(v, 114);
    v = '{1'b0, 5'd0, 4'd0, 72'd0, 1'b1, 1'b0, 1'b1, 5'd1, 8'hC1, 1'b0};
    apply(v, 115);
    v = '{1'b0, 5'd0, 4'd0, 72'd0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1};
    apply(v, 116);
    v = '{1'b0, 5'd0, 4'd0, 72'd0, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0};
    apply(v, 117);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
